vedic_prod_accum: RTL and testbench

//  Accumulator stage directly downstream of the 4x4 Vedic multiplier. Consumes the 8-bit

---
 rtl/vedic_prod_accum.sv | 109 ++++++++++
 tb/tb_vedic_prod_accum.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_prod_accum.sv
// Accumulates N_TERMS unsigned 8-bit products into one result. The result is
// presented on a valid/ready handshake and can either saturate or wrap on overflow.
module vedic_prod_accum #(
  parameter int ACC_W    = 16,
  parameter int N_TERMS  = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic [7:0]       term_cnt
);

  typedef enum logic {S_ACCUM = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  state_t           r_state, w_state_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [ACC_W-1:0] r_acc_out, w_acc_out_next;
  logic             r_flag, w_flag_next;
  logic             r_ovf, w_ovf_next;
  logic [7:0]       r_term_cnt, w_cnt_next;

  logic             w_accept;
  logic [ACC_W:0]   w_sum;
  logic             w_flag_sum;
  logic [ACC_W-1:0] w_acc_sum;

  assign prod_ready = (r_state == S_ACCUM) && !clr && !rst;
  assign w_accept   = prod_valid && prod_ready;

  // The extra top bit of the sum is the carry out that marks overflow.
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - 8){1'b0}}, prod_in};
  assign w_flag_sum = r_flag | w_sum[ACC_W];
  assign w_acc_sum  = (SATURATE && w_flag_sum) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  always_comb begin
    w_state_next   = r_state;
    w_acc_next     = r_acc;
    w_acc_out_next = r_acc_out;
    w_flag_next    = r_flag;
    w_ovf_next     = r_ovf;
    w_cnt_next     = r_term_cnt;
    if (clr) begin
      w_state_next = S_ACCUM;
      w_acc_next   = '0;
      w_flag_next  = 1'b0;
      w_ovf_next   = 1'b0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            w_acc_next  = w_acc_sum;
            w_flag_next = w_flag_sum;
            w_cnt_next  = r_term_cnt + 8'd1;
            if (r_term_cnt == LAST_CNT) begin
              w_state_next   = S_HOLD;
              w_acc_out_next = w_acc_sum;
              w_ovf_next     = w_flag_sum;
            end
          end
        end
        S_HOLD: begin
          // The result registers keep the delivered value until the next frame loads.
          if (acc_ready) begin
            w_state_next = S_ACCUM;
            w_acc_next   = '0;
            w_flag_next  = 1'b0;
            w_cnt_next   = '0;
          end
        end
        default: w_state_next = S_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_ACCUM;
      r_acc      <= '0;
      r_acc_out  <= '0;
      r_flag     <= 1'b0;
      r_ovf      <= 1'b0;
      r_term_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_acc      <= w_acc_next;
      r_acc_out  <= w_acc_out_next;
      r_flag     <= w_flag_next;
      r_ovf      <= w_ovf_next;
      r_term_cnt <= w_cnt_next;
    end
  end

  assign acc_out   = r_acc_out;
  assign acc_valid = (r_state == S_HOLD);
  assign ovf       = r_ovf;
  assign term_cnt  = r_term_cnt;

endmodule

// File: tb/tb_vedic_prod_accum.sv
// Testbench for vedic_prod_accum. It drives stimulus from a table and from a scoreboard,
// and uses two extra instances with a narrow accumulator to cover saturate and wrap.
`timescale 1ns/1ps
module tb_vedic_prod_accum;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [7:0]  prod_in;
  logic        prod_valid, prod_ready;
  logic [15:0] acc_out;
  logic        acc_valid, acc_ready, ovf;
  logic [7:0]  term_cnt;

  logic [7:0]  s_prod_in;
  logic        s_prod_valid, s_acc_ready;
  logic        sat_ready, sat_valid, sat_ovf, wrp_ready, wrp_valid, wrp_ovf;
  logic [9:0]  sat_out, wrp_out;
  logic [7:0]  sat_cnt, wrp_cnt;

  always #5 clk = ~clk;

  vedic_prod_accum #(.ACC_W(16), .N_TERMS(N), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .ovf(ovf), .term_cnt(term_cnt));

  vedic_prod_accum #(.ACC_W(10), .N_TERMS(5), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .prod_in(s_prod_in), .prod_valid(s_prod_valid),
    .prod_ready(sat_ready), .acc_out(sat_out), .acc_valid(sat_valid),
    .acc_ready(s_acc_ready), .ovf(sat_ovf), .term_cnt(sat_cnt));

  vedic_prod_accum #(.ACC_W(10), .N_TERMS(5), .SATURATE(1'b0)) dut_wrp (
    .clk(clk), .rst(rst), .clr(clr), .prod_in(s_prod_in), .prod_valid(s_prod_valid),
    .prod_ready(wrp_ready), .acc_out(wrp_out), .acc_valid(wrp_valid),
    .acc_ready(s_acc_ready), .ovf(wrp_ovf), .term_cnt(wrp_cnt));

  typedef struct packed { logic [15:0] sum; logic ovf; } exp_t;
  typedef struct packed { logic [3:0][7:0] p; logic [15:0] sum; logic ovf; } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_res = 0;
  int   m_sum, m_cnt;
  logic m_ovf;
  logic rnd_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sum = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Reference model: an integer sum that clamps at 65535.
  task automatic model_accept(input logic [7:0] p);
    m_sum = m_sum + int'(p);
    m_cnt++;
    if (m_sum > 65535) begin
      m_sum = 65535;
      m_ovf = 1'b1;
    end
    if (m_cnt == N) begin
      sb.push_back('{sum: 16'(m_sum), ovf: m_ovf});
      model_reset();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call at posedge+1. Returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] p);
    int budget;
    budget     = 0;
    prod_in    = p;
    prod_valid = 1'b1;
    @(negedge clk);
    while (!prod_ready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (!prod_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: prod_ready=0, expected 1");
    end else begin
      @(posedge clk);
      #1;
      model_accept(p);
    end
    prod_valid = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] p);
    int budget;
    budget       = 0;
    s_prod_in    = p;
    s_prod_valid = 1'b1;
    @(negedge clk);
    while (!(sat_ready && wrp_ready) && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (!(sat_ready && wrp_ready)) begin
      n_vec++;
      n_err++;
      $display("FAIL send_s_timeout: ready=%0d/%0d, expected 1/1", sat_ready, wrp_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    s_prod_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && acc_valid && acc_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got acc_out=%0d, expected no result", acc_out);
      end else begin
        e = sb.pop_front();
        n_res++;
        $display("result %0d: acc_out=%0d ovf=%0d (expected %0d/%0d)",
                 n_res, acc_out, ovf, e.sum, e.ovf);
        check("sb_acc_out", 32'(acc_out), 32'(e.sum));
        check("sb_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    tbl[0] = '{p: {8'd225, 8'd225, 8'd225, 8'd225}, sum: 16'd900,  ovf: 1'b0};
    tbl[1] = '{p: {8'd0,   8'd0,   8'd0,   8'd0},   sum: 16'd0,    ovf: 1'b0};
    tbl[2] = '{p: {8'd4,   8'd3,   8'd2,   8'd1},   sum: 16'd10,   ovf: 1'b0};
    tbl[3] = '{p: {8'd255, 8'd255, 8'd255, 8'd255}, sum: 16'd1020, ovf: 1'b0};
    tbl[4] = '{p: {8'd7,   8'd50,  8'd0,   8'd100}, sum: 16'd157,  ovf: 1'b0};
    tbl[5] = '{p: {8'd0,   8'd1,   8'd240, 8'd226}, sum: 16'd467,  ovf: 1'b0};

    rst = 1'b1; clr = 1'b0; prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b0;
    s_prod_in = '0; s_prod_valid = 1'b0; s_acc_ready = 1'b1; rnd_done = 1'b0;
    model_reset();
    #1;
    check("rst_prod_ready", 32'(prod_ready), 0);
    check("rst_acc_valid", 32'(acc_valid), 0);
    check("rst_acc_out", 32'(acc_out), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_term_cnt", 32'(term_cnt), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table frames, back-to-back, with the consumer always ready.
    acc_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) send(tbl[i].p[j]);
      @(negedge clk);
      check("tbl_acc_valid", 32'(acc_valid), 1);
      check("tbl_acc_out", 32'(acc_out), 32'(tbl[i].sum));
      check("tbl_ovf", 32'(ovf), 32'(tbl[i].ovf));
      check("tbl_term_cnt", 32'(term_cnt), N);
      @(negedge clk);
      check("tbl_valid_one_cycle", 32'(acc_valid), 0);
      check("tbl_term_cnt_clear", 32'(term_cnt), 0);
      @(posedge clk); #1;
    end

    // Saturating and wrapping instances with ACC_W=10 and N_TERMS=5.
    for (int j = 0; j < 5; j++) send_s(8'd225);
    @(negedge clk);
    check("sat_valid", 32'(sat_valid), 1);
    check("sat_out", 32'(sat_out), 32'h3FF);
    check("sat_ovf", 32'(sat_ovf), 1);
    check("sat_term_cnt", 32'(sat_cnt), 5);
    check("wrp_valid", 32'(wrp_valid), 1);
    check("wrp_out", 32'(wrp_out), 101);
    check("wrp_ovf", 32'(wrp_ovf), 1);
    @(posedge clk); #1;
    for (int j = 0; j < 5; j++) send_s(8'd1);
    @(negedge clk);
    check("sat_out_next", 32'(sat_out), 5);
    check("sat_ovf_next", 32'(sat_ovf), 0);
    check("wrp_out_next", 32'(wrp_out), 5);
    check("wrp_ovf_next", 32'(wrp_ovf), 0);
    check("wrp_term_cnt", 32'(wrp_cnt), 5);
    @(posedge clk); #1;

    // Backpressure: the result holds and new products are refused.
    acc_ready = 1'b0;
    send(8'd10); send(8'd10); send(8'd10); send(8'd6);
    prod_in = 8'd99; prod_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_acc_valid", 32'(acc_valid), 1);
      check("bp_acc_out", 32'(acc_out), 36);
      check("bp_prod_ready", 32'(prod_ready), 0);
    end
    @(posedge clk); #1;
    prod_valid = 1'b0; acc_ready = 1'b1;
    idle(2);

    // clr mid-frame, then a fresh frame.
    send(8'd10); send(8'd20);
    clr = 1'b1; prod_in = 8'd50; prod_valid = 1'b1;
    @(negedge clk);
    check("clr_prod_ready", 32'(prod_ready), 0);
    @(posedge clk); #1;
    clr = 1'b0; prod_valid = 1'b0;
    model_reset();
    check("clr_term_cnt", 32'(term_cnt), 0);
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    @(negedge clk);
    check("clr_acc_out", 32'(acc_out), 10);
    @(posedge clk); #1;

    // clr in HOLD drops the undelivered result.
    acc_ready = 1'b0;
    send(8'd50); send(8'd50); send(8'd50); send(8'd50);
    void'(sb.pop_back());
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clrh_acc_valid", 32'(acc_valid), 0);
    check("clrh_term_cnt", 32'(term_cnt), 0);
    check("clrh_acc_out_kept", 32'(acc_out), 200);
    acc_ready = 1'b1;

    // Asynchronous reset mid-frame.
    send(8'd5); send(8'd5);
    #2 rst = 1'b1;
    #1;
    check("arst_acc_out", 32'(acc_out), 0);
    check("arst_term_cnt", 32'(term_cnt), 0);
    check("arst_prod_ready", 32'(prod_ready), 0);
    check("arst_acc_valid", 32'(acc_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Asynchronous reset in HOLD.
    acc_ready = 1'b0;
    send(8'd7); send(8'd7); send(8'd7); send(8'd7);
    void'(sb.pop_back());
    @(negedge clk);
    check("hold_acc_out", 32'(acc_out), 28);
    #2 rst = 1'b1;
    #1;
    check("arsth_acc_out", 32'(acc_out), 0);
    check("arsth_acc_valid", 32'(acc_valid), 0);
    check("arsth_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    acc_ready = 1'b1;
    send(8'd3); send(8'd3); send(8'd3); send(8'd3);
    @(negedge clk);
    check("post_rst_acc_out", 32'(acc_out), 12);
    @(posedge clk); #1;

    // Random gaps, random consumer readiness, 200 frames.
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          acc_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int f = 0; f < 200; f++) begin
          for (int j = 0; j < 4; j++) begin
            idle($urandom_range(0, 3));
            send(8'($urandom_range(0, 255)));
          end
        end
        rnd_done = 1'b1;
      end
    join
    acc_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
